// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: data width and op codes.
package muldiv_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MD_OP_W    = 3;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // True for the four operations that occupy the iterative datapath.
  function automatic logic isMulDiv(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) | (op == MD_MULTU) | (op == MD_DIV) | (op == MD_DIVU);
  endfunction

  // True for the operations that treat their operands as two's complement.
  function automatic logic isSignedOp(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) | (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage (master) and the mul/div unit (slave).
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic               md_start;
  logic [MD_OP_W-1:0] md_op;
  data_t              md_a;
  data_t              md_b;
  logic               md_flush;
  data_t              hi;
  data_t              lo;
  logic               md_busy;
  logic               md_stall;
  logic               md_done;

  modport master (
    output md_start, md_op, md_a, md_b, md_flush,
    input  hi, lo, md_busy, md_stall, md_done
  );

  modport slave (
    input  md_start, md_op, md_a, md_b, md_flush,
    output hi, lo, md_busy, md_stall, md_done
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply and restoring divide sharing
// one 64-bit accumulator, one bit per cycle, with sign fix-up in a final FIX cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int CYCLES = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  data_t            b_q, b_d;
  logic             isDiv_q, isDiv_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;
  data_t            hi_q, hi_d;
  data_t            lo_q, lo_d;

  logic        idle;
  logic        accept;
  logic        aNeg, bNeg;
  data_t       aMag, bMag;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] divTrial;
  logic [63:0] divNext;
  logic [63:0] prodFix;
  data_t       quotFix, remFix;

  assign idle   = (state_q == IDLE);
  assign accept = bus.md_start & isMulDiv(bus.md_op) & idle & ~bus.md_flush;

  // Signed ops iterate on magnitudes; the result signs are remembered for FIX.
  assign aNeg = isSignedOp(bus.md_op) & bus.md_a[DATA_WIDTH-1];
  assign bNeg = isSignedOp(bus.md_op) & bus.md_b[DATA_WIDTH-1];
  assign aMag = aNeg ? data_t'(-bus.md_a) : bus.md_a;
  assign bMag = bNeg ? data_t'(-bus.md_b) : bus.md_b;

  // Multiply step: conditionally add multiplicand to the upper half, shift right.
  assign mulSum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mulNext = {mulSum, acc_q[31:1]};

  // Restoring divide step: trial subtract on the shifted remainder, quotient bit in LSB.
  assign divTrial = acc_q[63:31] - {1'b0, b_q};
  assign divNext  = divTrial[32] ? {acc_q[62:0], 1'b0}
                                 : {divTrial[31:0], acc_q[30:0], 1'b1};

  assign prodFix = negQ_q ? -acc_q : acc_q;
  assign quotFix = negQ_q ? data_t'(-acc_q[31:0])  : acc_q[31:0];
  assign remFix  = negR_q ? data_t'(-acc_q[63:32]) : acc_q[63:32];

  // State register; reset or any flush lands in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush outranks every transition.
  always_comb begin
    state_d = state_q;
    if (bus.md_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = RUN;
        RUN:     if (cnt_q == CNT_LAST) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and HI/LO next values; HI/LO only change in FIX or on MTHI/MTLO.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    isDiv_d = isDiv_q;
    negQ_d  = negQ_q;
    negR_d  = negR_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bus.md_flush) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (accept) begin
            acc_d   = {32'd0, aMag};
            b_d     = bMag;
            isDiv_d = (bus.md_op == MD_DIV) | (bus.md_op == MD_DIVU);
            negQ_d  = aNeg ^ bNeg;
            negR_d  = aNeg;
          end else if (bus.md_start && bus.md_op == MD_MTHI) begin
            hi_d = bus.md_a;
          end else if (bus.md_start && bus.md_op == MD_MTLO) begin
            lo_d = bus.md_a;
          end
        end
        RUN: begin
          acc_d = isDiv_q ? divNext : mulNext;
          cnt_d = cnt_q + 1'b1;
        end
        FIX: begin
          cnt_d = '0;
          if (isDiv_q) begin
            hi_d = remFix;
            lo_d = quotFix;
          end else begin
            hi_d = prodFix[63:32];
            lo_d = prodFix[31:0];
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Datapath registers; reset clears the counter and architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      isDiv_q <= 1'b0;
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      isDiv_q <= isDiv_d;
      negQ_q  <= negQ_d;
      negR_q  <= negR_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs: done only in an unflushed FIX, stall covers the accepting cycle too.
  always_comb begin
    bus.hi       = hi_q;
    bus.lo       = lo_q;
    bus.md_busy  = (state_q == RUN) | (state_q == FIX);
    bus.md_done  = (state_q == FIX) & ~bus.md_flush;
    bus.md_stall = (bus.md_start & isMulDiv(bus.md_op) & idle) | bus.md_busy;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus directed corners.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int CYCLES = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  muldiv_unit_if bus ();

  muldiv_unit #(.CYCLES(CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial forever #5 clk = ~clk;

  // Reference result {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      MD_MULT:  p = 64'(sa * sb);
      MD_MULTU: p = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 0) p = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else        p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic flush);
    @(posedge clk);
    #1;
    bus.md_start = start;
    bus.md_op    = op;
    bus.md_a     = a;
    bus.md_b     = b;
    bus.md_flush = flush;
  endtask

  // Behavioural model: remaining cycles of the operation in flight and pending result.
  int          remain = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;
  logic [63:0] pend  = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        remain = 0;
        expHi  = '0;
        expLo  = '0;
      end else if (bus.md_flush) begin
        remain = 0;
      end else if (remain == 1) begin
        expHi  = pend[63:32];
        expLo  = pend[31:0];
        remain = 0;
      end else if (remain > 1) begin
        remain = remain - 1;
      end else if (bus.md_start) begin
        if (isMulDiv(bus.md_op)) begin
          pend   = refResult(bus.md_op, bus.md_a, bus.md_b);
          remain = CYCLES + 1;
        end else if (bus.md_op == MD_MTHI) expHi = bus.md_a;
        else if (bus.md_op == MD_MTLO) expLo = bus.md_a;
      end
    end
  end

  // Compare every output against the model on each falling edge out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("hi", bus.hi, expHi);
        checkOutput("lo", bus.lo, expLo);
        checkOutput("busy", 32'(bus.md_busy), 32'(remain > 0));
        checkOutput("done", 32'(bus.md_done), 32'((remain == 1) && !bus.md_flush));
        checkOutput("stall", 32'(bus.md_stall),
                    32'((remain > 0) || (bus.md_start && isMulDiv(bus.md_op))));
      end
    end
  end

  function automatic logic [31:0] randOperand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Counts falling edges until md_done, bounded so a dead unit cannot hang the run.
  task automatic waitDone(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.md_done && k < 200);
  endtask

  // Completes an operation whose start is already driven, then checks latency and HI/LO.
  task automatic finishOp(input string name, input logic [31:0] hiExp, input logic [31:0] loExp);
    int k;
    applyStimulus(1'b0, MD_MULTU, '0, '0, 1'b0);
    waitDone(k);
    checkOutput({name, "_latency"}, 32'(k), 32'(CYCLES + 1));
    @(posedge clk);
    #1;
    checkOutput({name, "_hi"}, bus.hi, hiExp);
    checkOutput({name, "_lo"}, bus.lo, loExp);
    @(negedge clk);
    checkOutput({name, "_doneOnce"}, 32'(bus.md_done), 32'd0);
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hiExp, input logic [31:0] loExp);
    applyStimulus(1'b1, op, a, b, 1'b0);
    finishOp(name, hiExp, loExp);
  endtask

  // Main sequence: reset, model pins, directed corners, then random traffic.
  initial begin
    logic [63:0] r;
    int k;
    bus.md_start = 1'b0;
    bus.md_op    = MD_MULT;
    bus.md_a     = '0;
    bus.md_b     = '0;
    bus.md_flush = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    r = refResult(MD_MULT, 32'hFFFFFFFD, 32'd7);
    checkOutput("pinMultHi", r[63:32], 32'hFFFFFFFF);
    checkOutput("pinMultLo", r[31:0], 32'hFFFFFFEB);
    r = refResult(MD_DIV, 32'hFFFFFFF9, 32'd2);
    checkOutput("pinDivQ", r[31:0], 32'hFFFFFFFD);
    checkOutput("pinDivR", r[63:32], 32'hFFFFFFFF);
    r = refResult(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("pinOvfQ", r[31:0], 32'h80000000);

    @(negedge clk);
    checkOutput("resetHi", bus.hi, 32'd0);
    checkOutput("resetLo", bus.lo, 32'd0);
    checkOutput("resetBusy", 32'(bus.md_busy), 32'd0);

    runOp("multuMax", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    runOp("multNeg", MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("divNeg", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divuZero", MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    runOp("divOvf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // Flush in RUN cycle 10 of a DIVU.
    applyStimulus(1'b1, MD_DIVU, 32'd1000, 32'd3, 1'b0);
    applyStimulus(1'b0, MD_DIVU, 32'd0, 32'd0, 1'b0);
    repeat (9) applyStimulus(1'b0, MD_DIVU, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, MD_DIVU, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, MD_DIVU, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("flushRunBusy", 32'(bus.md_busy), 32'd0);
    checkOutput("flushRunHi", bus.hi, 32'h0);
    checkOutput("flushRunLo", bus.lo, 32'h80000000);

    // Flush during FIX suppresses done and the HI/LO write.
    applyStimulus(1'b1, MD_MULTU, 32'd5, 32'd6, 1'b0);
    applyStimulus(1'b0, MD_MULTU, 32'd0, 32'd0, 1'b0);
    repeat (31) applyStimulus(1'b0, MD_MULTU, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, MD_MULTU, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("flushFixDone", 32'(bus.md_done), 32'd0);
    checkOutput("flushFixBusy", 32'(bus.md_busy), 32'd1);
    applyStimulus(1'b0, MD_MULTU, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("flushFixLo", bus.lo, 32'h80000000);

    // MTHI in IDLE, and MTLO killed by a simultaneous flush.
    applyStimulus(1'b1, MD_MTHI, 32'h12345678, 32'd0, 1'b0);
    applyStimulus(1'b0, MD_MTHI, 32'd0, 32'd0, 1'b0);
    checkOutput("mthiHi", bus.hi, 32'h12345678);
    applyStimulus(1'b1, MD_MTLO, 32'hDEADBEEF, 32'd0, 1'b1);
    applyStimulus(1'b0, MD_MTLO, 32'd0, 32'd0, 1'b0);
    checkOutput("mtloFlushLo", bus.lo, 32'h80000000);

    // MTLO while a multiply runs is stalled and ignored.
    applyStimulus(1'b1, MD_MULTU, 32'd6, 32'd7, 1'b0);
    applyStimulus(1'b0, MD_MULTU, 32'd0, 32'd0, 1'b0);
    applyStimulus(1'b1, MD_MTLO, 32'd55, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("mtloRunStall", 32'(bus.md_stall), 32'd1);
    applyStimulus(1'b0, MD_MTLO, 32'd0, 32'd0, 1'b0);
    waitDone(k);
    @(posedge clk);
    #1;
    checkOutput("mtloRunHi", bus.hi, 32'd0);
    checkOutput("mtloRunLo", bus.lo, 32'd42);

    // Asynchronous reset in the middle of RUN, then accept on the first edge after release.
    applyStimulus(1'b1, MD_MULTU, 32'd9, 32'd9, 1'b0);
    repeat (5) applyStimulus(1'b0, MD_MULTU, 32'd0, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstHi", bus.hi, 32'd0);
    checkOutput("rstLo", bus.lo, 32'd0);
    checkOutput("rstBusy", 32'(bus.md_busy), 32'd0);
    checkOutput("rstDone", 32'(bus.md_done), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.md_start = 1'b1;
    bus.md_op    = MD_DIVU;
    bus.md_a     = 32'd1000;
    bus.md_b     = 32'd7;
    finishOp("postRst", 32'd6, 32'd142);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), randOperand(),
                    randOperand(), $urandom_range(0, 199) == 0);
    end
    applyStimulus(1'b0, MD_MULT, '0, '0, 1'b0);
    repeat (CYCLES + 4) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter CYCLES, default 32, giving the number of iteration cycles (one bit per cycle).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port md_start, input, 1, a one-cycle request from the EX stage.
REQ-005 SHALL have port md_op, input, 3, selecting MULT, MULTU, DIV, DIVU, MTHI or MTLO (codes in common.vh).
REQ-006 SHALL have ports md_a and md_b, input, `DATA_BUS, the rs and rt operands.
REQ-007 SHALL have port md_flush, input, 1, the pipeline flush/exception kill.
REQ-008 SHALL have ports hi and lo, output, `DATA_BUS, the architectural HI/LO registers.
REQ-009 SHALL have port md_busy, output, 1, high in RUN and FIX; the pipeline gates MFHI/MFLO with it.
REQ-010 SHALL have port md_stall, output, 1, combinational (md_start & mul/div op & IDLE) | md_busy.
REQ-011 SHALL have port md_done, output, 1, a one-cycle pulse in the cycle HI/LO are written by a mul/div.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; IDLE->RUN on accepted mul/div start, RUN->FIX when the iteration counter reaches CYCLES-1, FIX->IDLE unconditionally.
REQ-013 SHALL accept md_start only in IDLE; md_start in RUN/FIX SHALL be ignored (the pipeline holds it via md_stall).
REQ-014 SHALL on MTHI/MTLO in IDLE write md_a to hi/lo at the next edge, stay in IDLE, and not pulse md_done.
REQ-015 SHALL for signed ops latch |md_a|, |md_b| and result signs at accept; unsigned ops latch raw operands.
REQ-016 SHALL multiply by shift-add, one multiplier bit per RUN cycle, into a 64-bit accumulator.
REQ-017 SHALL divide by restoring shift-subtract, one quotient bit per RUN cycle.
REQ-018 SHALL in FIX apply sign correction (product sign a^b; quotient sign a^b; remainder sign of a) and write hi/lo: MULT hi:lo = product, DIV lo = quotient, hi = remainder.
REQ-019 SHALL have latency: accept edge N, md_done high in cycle N+CYCLES+1, hi/lo new values visible from N+CYCLES+2.
REQ-020 SHALL on divide by zero run full latency and yield lo = 32'hFFFFFFFF, hi = md_a (unsigned) / sign-corrected equivalents (signed).
REQ-021 SHALL on DIV 32'h80000000 / 32'hFFFFFFFF yield lo = 32'h80000000, hi = 0.
REQ-022 SHALL on md_flush in any state return to IDLE at the next edge, leave hi/lo unchanged, suppress md_done.
REQ-023 SHALL give md_flush priority over a simultaneous md_start, including MTHI/MTLO.
REQ-024 SHALL keep hi/lo stable during RUN; only FIX or MTHI/MTLO write them.

Reset
REQ-025 SHALL on rst_n low asynchronously force IDLE, counter 0, hi = 0, lo = 0, md_done = 0, md_busy = 0.
REQ-026 SHALL discard any in-flight operation on reset mid-RUN; first accept is allowed on the first edge after rst_n rises.

Structure
REQ-027 SHALL take `DATA_BUS/`DATA_WIDTH from common.vh and add the MD_OP codes and MD_OP_BUS there.
REQ-028 SHALL keep state encoding as local parameters inside the module.
REQ-029 SHALL be a single module; no sub-module is natural since mul and div share the accumulator, counter and FIX logic.

Verification
REQ-030 SHALL cover MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 34 cycles hi = 32'hFFFFFFFE, lo = 32'h00000001, md_done one cycle.
REQ-031 SHALL cover MULT -3 x 7 -> hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB.
REQ-032 SHALL cover DIV -7 / 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF; DIVU 100 / 0 -> lo = 32'hFFFFFFFF, hi = 100.
REQ-033 SHALL cover start DIVU, md_flush at RUN cycle 10 -> IDLE next edge, hi/lo unchanged, no md_done.
REQ-034 SHALL cover MTHI 32'h12345678 in IDLE -> hi = 32'h12345678 next edge; MTLO during RUN -> ignored, md_stall high.
REQ-035 SHALL cover rst_n low mid-RUN -> hi = lo = 0 immediately, md_busy = 0 with no clock edge.
